// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state and port id definitions for the data memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin pick, purely combinational
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        winner = PORT0;
        gnt    = 2'b00;
        case (req)
            2'b01:   winner = PORT0;
            2'b10:   winner = PORT1;
            2'b11:   winner = ~last_winner;
            default: winner = PORT0;
        endcase
        if (req != 2'b00) begin
            gnt = (winner == PORT1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin sequencer in front of a single-port data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    logic              r_last_winner;
    logic              r_port;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_p0_rvalid;
    logic              r_p1_rvalid;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;
    logic              r_p0_err;
    logic              r_p1_err;

    logic [1:0]        w_arb_gnt;
    logic [1:0]        w_gnt;
    logic              w_winner;
    logic              w_can_grant;
    logic              w_accept;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_in_range;
    logic [DATA_W-1:0] w_cap_rdata;

    rr_arbiter2 u_rr (
        .req         ({p1_req, p0_req}),
        .last_winner (r_last_winner),
        .gnt         (w_arb_gnt),
        .winner      (w_winner)
    );

    // Grants are masked while reset is held so no request can be accepted out of reset state.
    assign w_can_grant    = !rst && (r_state != ACCESS);
    assign w_gnt          = w_can_grant ? w_arb_gnt : 2'b00;
    assign w_accept       = |w_gnt;

    assign w_sel_we       = (w_winner == PORT1) ? p1_we    : p0_we;
    assign w_sel_addr     = (w_winner == PORT1) ? p1_addr  : p0_addr;
    assign w_sel_wdata    = (w_winner == PORT1) ? p1_wdata : p0_wdata;
    assign w_sel_in_range = ({1'b0, w_sel_addr} < LP_DEPTH);
    assign w_cap_rdata    = r_err ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_winner <= PORT1;
            r_port        <= PORT0;
            r_err         <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
            r_p0_rvalid   <= 1'b0;
            r_p1_rvalid   <= 1'b0;
        end else begin
            r_mem_we    <= 1'b0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_state       <= ACCESS;
                        r_last_winner <= w_winner;
                        r_port        <= w_winner;
                        r_err         <= !w_sel_in_range;
                        r_mem_addr    <= w_sel_addr;
                        r_mem_wdata   <= w_sel_wdata;
                        r_mem_we      <= w_sel_we && w_sel_in_range;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ACCESS: begin
                    r_state     <= RESP;
                    r_p0_rvalid <= (r_port == PORT0);
                    r_p1_rvalid <= (r_port == PORT1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Only the owning port's read data and error flag move; the other port holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
            r_p0_err   <= 1'b0;
            r_p1_err   <= 1'b0;
        end else if (r_state == ACCESS) begin
            if (r_port == PORT0) begin
                r_p0_rdata <= w_cap_rdata;
                r_p0_err   <= r_err;
            end else begin
                r_p1_rdata <= w_cap_rdata;
                r_p1_err   <= r_err;
            end
        end
    end

    assign p0_gnt    = w_gnt[0];
    assign p1_gnt    = w_gnt[1];
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;
    assign p0_err    = r_p0_err;
    assign p1_err    = r_p1_err;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state == ACCESS);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a memory and reference model
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we  = 2'b00;
    logic [15:0] addr_a  [2];
    logic [31:0] wdata_a [2];
    wire  [1:0]  gnt;
    wire  [1:0]  rvalid;
    wire  [1:0]  err;
    wire  [31:0] rdata0;
    wire  [31:0] rdata1;
    wire  [15:0] mem_addr;
    wire         mem_we;
    wire  [31:0] mem_wdata;
    wire  [31:0] mem_rdata;
    wire         busy;

    logic [31:0] mem [256];
    logic        mem_load = 1'b1;
    int          we_total = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] exp_rdata [2];
    logic        exp_err [2];
    int          last_win;
    int          n_assert = 0;
    int          n_fail   = 0;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (req[0]),
        .p0_we     (we[0]),
        .p0_addr   (addr_a[0]),
        .p0_wdata  (wdata_a[0]),
        .p0_gnt    (gnt[0]),
        .p0_rvalid (rvalid[0]),
        .p0_rdata  (rdata0),
        .p0_err    (err[0]),
        .p1_req    (req[1]),
        .p1_we     (we[1]),
        .p1_addr   (addr_a[1]),
        .p1_wdata  (wdata_a[1]),
        .p1_gnt    (gnt[1]),
        .p1_rvalid (rvalid[1]),
        .p1_rdata  (rdata1),
        .p1_err    (err[1]),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'd5;
        if (i == 1) return 32'd3;
        return 32'hA500_0000 | 32'(i);
    endfunction

    assign mem_rdata = (mem_addr < 16'd256) ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_we && mem_addr < 16'd256) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    always @(negedge clk) if (mem_we) we_total <= we_total + 1;

    function automatic logic [31:0] rd(input int p);
        return (p == 1) ? rdata1 : rdata0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction from IDLE; optionally pulses the other port's req during ACCESS.
    task automatic do_access(input int p, input logic w, input logic [15:0] a,
                             input logic [31:0] d, input bit pulse);
        int          o;
        int          we0;
        logic        inr;
        logic [31:0] exp_rd;
        o      = 1 - p;
        inr    = (a < 16'd256);
        exp_rd = inr ? ref_mem[a[7:0]] : 32'h0;
        we0    = we_total;
        req[p] = 1'b1; we[p] = w; addr_a[p] = a; wdata_a[p] = d;
        @(negedge clk);
        chk("gnt_own", gnt[p], 1'b1);
        chk("gnt_other", gnt[o], 1'b0);
        @(posedge clk); #1;
        req[p] = 1'b0;
        if (pulse) begin
            req[o] = 1'b1; we[o] = 1'b1; addr_a[o] = a ^ 16'h1; wdata_a[o] = ~d;
        end
        @(negedge clk);
        chk("busy_access", busy, 1'b1);
        chk("gnt_in_access", gnt, 2'b00);
        chk("mem_addr", mem_addr, a);
        chk("mem_we_access", mem_we, w && inr);
        if (w) chk("mem_wdata", mem_wdata, d);
        @(posedge clk); #1;
        req[o] = 1'b0;
        @(negedge clk);
        chk("rvalid_resp", rvalid, (p == 1) ? 2'b10 : 2'b01);
        chk("rdata_own", rd(p), exp_rd);
        chk("err_own", err[p], !inr);
        chk("rdata_other_hold", rd(o), exp_rdata[o]);
        chk("err_other_hold", err[o], exp_err[o]);
        chk("mem_we_resp", mem_we, 1'b0);
        chk("gnt_resp_idle", gnt, 2'b00);
        exp_rdata[p] = exp_rd;
        exp_err[p]   = !inr;
        last_win     = p;
        if (w && inr) ref_mem[a[7:0]] = d;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rvalid_after", rvalid, 2'b00);
        chk("mem_we_cycles", 32'(we_total - we0), (w && inr) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int          win [4];
        int          lst;
        int          q;
        logic [1:0]  exp_g;
        logic [1:0]  exp_v;
        int          rp;
        logic        rw;
        logic [15:0] ra;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 2; i++) begin
            addr_a[i] = '0; wdata_a[i] = '0; exp_rdata[i] = '0; exp_err[i] = 1'b0;
        end
        last_win = 1;

        // Reset with a pending request: everything must stay quiet.
        req[0] = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_err", err, 2'b00);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", {rdata1, rdata0}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_load = 1'b0; req = 2'b00;
        @(posedge clk); #1;

        do_access(0, 1'b0, 16'h0000, 32'h0, 1'b0);
        do_access(1, 1'b1, 16'h0003, 32'hDEADBEEF, 1'b0);
        do_access(0, 1'b0, 16'h0003, 32'h0, 1'b0);
        do_access(1, 1'b0, 16'h0001, 32'h0, 1'b0);

        // Both ports held high for four back-to-back transactions.
        lst = last_win;
        for (int k = 0; k < 4; k++) begin
            win[k] = 1 - lst;
            lst    = win[k];
        end
        we = 2'b00; addr_a[0] = 16'h0000; addr_a[1] = 16'h0001;
        req = 2'b11;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp_g = (c % 2 == 0 && c < 8) ? ((win[c/2] == 1) ? 2'b10 : 2'b01) : 2'b00;
            exp_v = (c % 2 == 0 && c >= 2) ? ((win[c/2-1] == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("tie_gnt", gnt, exp_g);
            chk("tie_rvalid", rvalid, exp_v);
            if (exp_v != 2'b00) begin
                q = win[c/2-1];
                chk("tie_rdata", rd(q), ref_mem[q]);
                chk("tie_err", err[q], 1'b0);
            end
            @(posedge clk); #1;
            if (c == 6) req = 2'b00;
        end
        last_win = win[3];
        exp_rdata[0] = ref_mem[0]; exp_rdata[1] = ref_mem[1];
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;

        do_access(0, 1'b1, 16'h0100, 32'h1234_5678, 1'b0);
        do_access(0, 1'b0, 16'h0000, 32'h0, 1'b0);

        // Reset lands in the middle of an ACCESS cycle for a write to addr 2.
        req[1] = 1'b1; we[1] = 1'b1; addr_a[1] = 16'h0002; wdata_a[1] = 32'h0BAD_F00D;
        @(negedge clk);
        chk("abort_gnt", gnt, 2'b10);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("abort_mem_we_before", mem_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_we_async", mem_we, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("abort_rvalid_rst", rvalid, 2'b00);
        rst = 1'b0;
        exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        last_win = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_no_rvalid", rvalid, 2'b00);
            chk("abort_rdata_clear", {rdata1, rdata0}, 64'h0);
            @(posedge clk); #1;
        end

        // Tie right after reset goes to port 0; port 1 is then granted in RESP.
        we = 2'b00; addr_a[0] = 16'h0002; addr_a[1] = 16'h0001;
        req = 2'b11;
        @(negedge clk);
        chk("post_rst_tie_gnt", gnt, 2'b01);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_access_gnt", gnt, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_rvalid0", rvalid, 2'b01);
        chk("addr2_unchanged", rdata0, ref_mem[2]);
        chk("resp_regrant_p1", gnt, 2'b10);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_rvalid1", rvalid, 2'b10);
        chk("post_rst_rdata1", rdata1, ref_mem[1]);
        exp_rdata[0] = ref_mem[2]; exp_rdata[1] = ref_mem[1];
        last_win = 1;
        @(posedge clk); #1;

        do_access(0, 1'b0, 16'h0000, 32'h0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            rp = int'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 9) == 0) ? 16'(256 + $urandom_range(0, 1000))
                                              : 16'($urandom_range(0, 15));
            do_access(rp, rw, ra, $urandom, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
